mem_access_stage: RTL and testbench

- Pipeline stage directly downstream of the execute ALU.
- Holds the EX/MEM register: ALU result, forwarded store data, destination register, control bits.
- Performs data-memory loads/stores over a valid/ready bus, with stall generation, a timeout, and misalignment checks.
- Drives the MEM/WB register consumed by writeback; exposes ALUOutM/WriteRegM/RegWriteM back to forwarding and hazard logic.

---
 rtl/mem_access_stage_pkg.sv | 25 ++
 rtl/mem_access_stage_dmem_handshake.sv | 72 +++++++
 rtl/mem_access_stage.sv | 140 ++++++++++++++
 tb/tb_mem_access_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// ============================================================================
// Module      : mem_access_stage_pkg
// Description : Shared types and constants for the memory-access pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_access_stage_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } dmem_state_t;

  localparam logic [31:0] c_word_align_mask = 32'hFFFF_FFFC;
  localparam int          c_default_timeout = 16;
  localparam int          c_default_cnt_w   = 5;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr & ~c_word_align_mask) == 32'h0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_stage_dmem_handshake.sv
// ============================================================================
// Module      : dmem_handshake
// Description : Data-memory request FSM with timeout counter, stall and sticky bus error.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_handshake
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = c_default_timeout,
  parameter int CNT_W          = c_default_cnt_w
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic dmem_ready,
  output logic busy,
  output logic StallM,
  output logic timeout_hit,
  output logic bus_err
);

  localparam logic [CNT_W-1:0] c_cnt_limit = CNT_W'(TIMEOUT_CYCLES - 1);

  dmem_state_t      r_state;
  dmem_state_t      w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_bus_err;
  logic             w_busy;
  logic             w_timeout_hit;
  logic             w_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // The next instruction is only sampled when the stage is not holding.
  always_comb begin
    w_next_state  = r_state;
    w_busy        = (r_state == BUSY);
    w_timeout_hit = w_busy & ~dmem_ready & (r_cnt == c_cnt_limit);
    w_stall       = w_busy & ~dmem_ready & ~w_timeout_hit;
    if (!w_stall) begin
      w_next_state = start ? BUSY : IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_cnt <= w_stall ? (r_cnt + CNT_W'(1)) : '0;
      if (w_timeout_hit) begin
        r_bus_err <= 1'b1;
      end
    end
  end

  assign busy        = w_busy;
  assign StallM      = w_stall;
  assign timeout_hit = w_timeout_hit;
  assign bus_err     = r_bus_err;

endmodule

`default_nettype wire

// File: rtl/mem_access_stage.sv
// ============================================================================
// Module      : mem_access_stage
// Description : MEM pipeline stage: EX/MEM and MEM/WB registers around a data-memory handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = c_default_timeout,
  parameter int CNT_W          = c_default_cnt_w
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ALUOutE,
  input  logic [31:0] WriteDataE,
  input  logic [4:0]  WriteRegE,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic        MemWriteE,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [31:0] ALUOutM,
  output logic [4:0]  WriteRegM,
  output logic        RegWriteM,
  output logic        StallM,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUOutW,
  output logic [4:0]  WriteRegW,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic        align_err,
  output logic        bus_err
);

  logic [31:0] r_alu_out_m;
  logic [31:0] r_write_data_m;
  logic [4:0]  r_write_reg_m;
  logic        r_reg_write_m;
  logic        r_mem_to_reg_m;
  logic        r_mem_write_m;

  logic [31:0] r_read_data_w;
  logic [31:0] r_alu_out_w;
  logic [4:0]  r_write_reg_w;
  logic        r_reg_write_w;
  logic        r_mem_to_reg_w;

  logic w_start;
  logic w_busy;
  logic w_stall;
  logic w_timeout_hit;
  logic w_misaligned_m;
  logic w_load_ok;

  assign w_start = (MemtoRegE | MemWriteE) & is_word_aligned(ALUOutE);

  dmem_handshake #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_handshake (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (w_start),
    .dmem_ready  (dmem_ready),
    .busy        (w_busy),
    .StallM      (w_stall),
    .timeout_hit (w_timeout_hit),
    .bus_err     (bus_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_out_m    <= '0;
      r_write_data_m <= '0;
      r_write_reg_m  <= '0;
      r_reg_write_m  <= 1'b0;
      r_mem_to_reg_m <= 1'b0;
      r_mem_write_m  <= 1'b0;
    end else if (!w_stall) begin
      r_alu_out_m    <= ALUOutE;
      r_write_data_m <= WriteDataE;
      r_write_reg_m  <= WriteRegE;
      r_reg_write_m  <= RegWriteE;
      r_mem_to_reg_m <= MemtoRegE;
      r_mem_write_m  <= MemWriteE;
    end
  end

  assign w_misaligned_m = (r_mem_to_reg_m | r_mem_write_m) & ~is_word_aligned(r_alu_out_m);
  assign w_load_ok      = w_busy & dmem_ready & r_mem_to_reg_m & ~r_mem_write_m;

  // A held stage sends a bubble downstream; aborted or misaligned accesses never write back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_read_data_w  <= '0;
      r_alu_out_w    <= '0;
      r_write_reg_w  <= '0;
      r_reg_write_w  <= 1'b0;
      r_mem_to_reg_w <= 1'b0;
    end else if (w_stall) begin
      r_read_data_w  <= '0;
      r_alu_out_w    <= '0;
      r_write_reg_w  <= '0;
      r_reg_write_w  <= 1'b0;
      r_mem_to_reg_w <= 1'b0;
    end else begin
      r_read_data_w  <= w_load_ok ? dmem_rdata : '0;
      r_alu_out_w    <= r_alu_out_m;
      r_write_reg_w  <= r_write_reg_m;
      r_reg_write_w  <= r_reg_write_m & ~w_timeout_hit & ~w_misaligned_m;
      r_mem_to_reg_w <= r_mem_to_reg_m;
    end
  end

  assign dmem_req   = w_busy;
  assign dmem_we    = w_busy & r_mem_write_m;
  assign dmem_addr  = r_alu_out_m & c_word_align_mask;
  assign dmem_wdata = r_write_data_m;

  assign ALUOutM   = r_alu_out_m;
  assign WriteRegM = r_write_reg_m;
  assign RegWriteM = r_reg_write_m;
  assign StallM    = w_stall;
  assign align_err = w_misaligned_m;

  assign ReadDataW = r_read_data_w;
  assign ALUOutW   = r_alu_out_w;
  assign WriteRegW = r_write_reg_w;
  assign RegWriteW = r_reg_write_w;
  assign MemtoRegW = r_mem_to_reg_w;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Randomized self-checking bench for mem_access_stage against an instruction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_stage;

  localparam int c_timeout = 16;
  localparam int c_n_instr = 250;

  logic        clk;
  logic        rst_n;
  logic [31:0] ALUOutE, WriteDataE, dmem_rdata;
  logic [4:0]  WriteRegE;
  logic        RegWriteE, MemtoRegE, MemWriteE, dmem_ready;
  logic        dmem_req, dmem_we, RegWriteM, StallM, RegWriteW, MemtoRegW, align_err, bus_err;
  logic [31:0] dmem_addr, dmem_wdata, ALUOutM, ReadDataW, ALUOutW;
  logic [4:0]  WriteRegM, WriteRegW;

  mem_access_stage #(
    .TIMEOUT_CYCLES (c_timeout),
    .CNT_W          (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ALUOutE    (ALUOutE),
    .WriteDataE (WriteDataE),
    .WriteRegE  (WriteRegE),
    .RegWriteE  (RegWriteE),
    .MemtoRegE  (MemtoRegE),
    .MemWriteE  (MemWriteE),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .ALUOutM    (ALUOutM),
    .WriteRegM  (WriteRegM),
    .RegWriteM  (RegWriteM),
    .StallM     (StallM),
    .ReadDataW  (ReadDataW),
    .ALUOutW    (ALUOutW),
    .WriteRegW  (WriteRegW),
    .RegWriteW  (RegWriteW),
    .MemtoRegW  (MemtoRegW),
    .align_err  (align_err),
    .bus_err    (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  wr;
    logic        rw;
    logic        m2r;
    logic        mw;
    int          waits;
    logic [31:0] rdata;
  } instr_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
  endtask

  function automatic instr_t mk(input int kind, input logic [31:0] alu, input logic [31:0] wd,
                                input int waits, input logic [31:0] rd);
    instr_t i;
    i.alu = alu; i.wd = wd; i.wr = 5'd7; i.rw = (kind != 2);
    i.m2r = (kind == 1); i.mw = (kind == 2); i.waits = waits; i.rdata = rd;
    return i;
  endfunction

  function automatic instr_t rnd_instr();
    instr_t i;
    int     kind;
    logic [31:0] a;
    kind = $urandom_range(0, 2);
    a    = $urandom;
    if (kind != 0 && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
    i = mk(kind, a, $urandom, 0, $urandom);
    i.wr = 5'($urandom);
    i.rw = ($urandom_range(0, 3) != 0);
    if ($urandom_range(0, 9) < 7) i.waits = $urandom_range(0, 3);
    else                          i.waits = $urandom_range(c_timeout - 3, c_timeout + 3);
    return i;
  endfunction

  instr_t dir_q[$];

  function automatic instr_t get_next();
    if (dir_q.size() > 0) return dir_q.pop_front();
    return rnd_instr();
  endfunction

  task automatic drive_e(input instr_t i);
    ALUOutE = i.alu; WriteDataE = i.wd; WriteRegE = i.wr;
    RegWriteE = i.rw; MemtoRegE = i.m2r; MemWriteE = i.mw;
  endtask

  initial begin
    instr_t cur, nxt, zero_i;
    int     k, issued, stalls;
    logic   is_mem, aligned, acc, exp_stall, aborted, exp_bus_err;
    logic [31:0] exp_rd;

    zero_i = mk(0, 32'h0, 32'h0, 0, 32'h0);
    zero_i.rw = 1'b0; zero_i.wr = 5'd0;
    rst_n = 1'b0; dmem_ready = 1'b0; dmem_rdata = '0;
    drive_e(zero_i);

    dir_q.push_back(mk(1, 32'h100, 32'h0, 0, 32'hCAFE0001));
    dir_q.push_back(mk(2, 32'h200, 32'h12345678, 3, 32'h0));
    dir_q.push_back(mk(1, 32'h300, 32'h0, 1000, 32'h0));
    dir_q.push_back(mk(1, 32'h103, 32'h0, 0, 32'h0));
    dir_q.push_back(mk(1, 32'h0, 32'h0, 0, 32'hAAAA0000));
    dir_q.push_back(mk(1, 32'h4, 32'h0, 0, 32'hBBBB0004));
    dir_q.push_back(mk(1, 32'h8, 32'h0, c_timeout - 1, 32'hD00D0008));
    dir_q.push_back(mk(0, 32'h55, 32'h0, 0, 32'h0));

    repeat (2) @(posedge clk);
    #1;
    check("rst_req", dmem_req, 0);
    check("rst_stall", StallM, 0);
    check("rst_alum", ALUOutM, 0);
    check("rst_rww", RegWriteW, 0);
    check("rst_rdw", ReadDataW, 0);
    check("rst_buserr", bus_err, 0);
    check("rst_alignerr", align_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    cur = zero_i; k = 0; issued = 0; exp_bus_err = 1'b0;
    nxt = get_next();
    while (issued < c_n_instr) begin
      @(negedge clk);
      drive_e(nxt);
      is_mem  = cur.m2r | cur.mw;
      aligned = (cur.alu[1:0] == 2'b00);
      acc     = is_mem & aligned;
      stalls  = acc ? ((cur.waits < c_timeout - 1) ? cur.waits : c_timeout - 1) : 0;
      exp_stall = (k < stalls);
      if (acc) begin
        dmem_ready = (k == cur.waits);
        dmem_rdata = (k == cur.waits) ? cur.rdata : $urandom;
      end else begin
        dmem_ready = 1'($urandom);
        dmem_rdata = $urandom;
      end
      #1;
      check("StallM", StallM, exp_stall);
      check("dmem_req", dmem_req, acc);
      check("align_err", align_err, is_mem & ~aligned);
      check("ALUOutM", ALUOutM, cur.alu);
      check("WriteRegM", WriteRegM, cur.wr);
      check("RegWriteM", RegWriteM, cur.rw);
      if (acc) begin
        check("dmem_addr", dmem_addr, cur.alu);
        check("dmem_we", dmem_we, cur.mw);
        check("dmem_wdata", dmem_wdata, cur.wd);
      end
      @(posedge clk);
      #1;
      if (exp_stall) begin
        check("bubble_RegWriteW", RegWriteW, 0);
        check("bubble_MemtoRegW", MemtoRegW, 0);
        k++;
      end else begin
        aborted = acc && (cur.waits > c_timeout - 1);
        exp_rd  = (acc && !aborted && cur.m2r) ? cur.rdata : 32'h0;
        if (aborted) exp_bus_err = 1'b1;
        check("ReadDataW", ReadDataW, exp_rd);
        check("ALUOutW", ALUOutW, cur.alu);
        check("WriteRegW", WriteRegW, cur.wr);
        check("RegWriteW", RegWriteW, cur.rw & ~aborted & ~(is_mem & ~aligned));
        check("MemtoRegW", MemtoRegW, cur.m2r);
        cur = nxt; k = 0; issued++;
        nxt = get_next();
      end
      check("bus_err", bus_err, exp_bus_err);
    end

    // Reset asserted while a load is waiting on the bus.
    begin
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        drive_e(mk(1, 32'h40, 32'h0, 0, 32'h0));
        dmem_ready = 1'b0;
        #1;
        if (dmem_req && StallM) begin
          seen = 1'b1;
          break;
        end
      end
      check("reset_setup_busy", seen, 1);
      #1 rst_n = 1'b0;
      #1;
      check("arst_req", dmem_req, 0);
      check("arst_stall", StallM, 0);
      check("arst_rww", RegWriteW, 0);
      check("arst_rdw", ReadDataW, 0);
      check("arst_aluw", ALUOutW, 0);
      check("arst_m2rw", MemtoRegW, 0);
      check("arst_buserr", bus_err, 0);
      @(negedge clk);
      drive_e(zero_i);
      rst_n = 1'b1;
      #1;
      check("post_rst_idle", dmem_req, 0);
      @(posedge clk);
      #1;
      check("post_rst_idle2", dmem_req, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
